// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and restoring divider
// sharing one 64-bit working register, with pipeline stall/done handshake.
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | one multiply/divide iteration per cycle
// DONE  | result presented, done pulse, pipeline released
module exe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   work, work_step, prod;
    logic [XLEN-1:0]     opnd, result_q;
    logic [2:0]          op_q;
    logic                neg_q, neg_r;

    logic                accept, a_sop, b_sop, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0]     a_mag, b_mag, special_res, quot, rem, final_res;
    logic [XLEN:0]       sum, rem_sh, trial;
    logic                stall_c, last;

    assign accept   = start & ~flush;
    assign a_sop    = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    assign b_sop    = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign a_neg    = a_sop & a[XLEN-1];
    assign b_neg    = b_sop & b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = op[2] & (b == '0);
    assign div_ovf  = ((op == 3'b100) | (op == 3'b110)) &
                      (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Divide shifts {rem,quot} left and trial-subtracts; multiply adds into the
    // upper half and shifts right, consuming multiplier bits from the low half.
    always_comb begin
        sum       = '0;
        rem_sh    = '0;
        trial     = '0;
        work_step = work;
        if (op_q[2]) begin
            rem_sh = work[2*XLEN-1:XLEN-1];
            trial  = rem_sh - {1'b0, opnd};
            if (!trial[XLEN])
                work_step = {trial[XLEN-1:0], work[XLEN-2:0], 1'b1};
            else
                work_step = {rem_sh[XLEN-1:0], work[XLEN-2:0], 1'b0};
        end else begin
            sum       = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
            work_step = {sum, work[XLEN-1:1]};
        end
    end

    assign prod = neg_q ? -work_step : work_step;
    assign quot = neg_q ? -work_step[XLEN-1:0] : work_step[XLEN-1:0];
    assign rem  = neg_r ? -work_step[2*XLEN-1:XLEN] : work_step[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot;
            default:                final_res = rem;
        endcase
    end

    assign last = (count == CW'(ITERS-1));

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            S_IDLE: begin
                stall_c = accept;
                if (accept)
                    state_nxt = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                stall_c = ~flush;
                if (last)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            work     <= '0;
            opnd     <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else if (state == S_IDLE && accept) begin
            count <= '0;
            work  <= {{XLEN{1'b0}}, a_mag};
            opnd  <= b_mag;
            op_q  <= op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special)
                result_q <= special_res;
        end else if (state == S_CALC && !flush) begin
            work  <= work_step;
            count <= count + 1'b1;
            if (last)
                result_q <= final_res;
        end
    end

    // The state register resets asynchronously, but start may still be high.
    assign stall  = rst_n & stall_c;
    assign done   = (state == S_DONE) & ~flush;
    assign result = result_q;

endmodule
